fetch_unit: RTL

Parametrised instruction-fetch front end for the next-generation core. Replaces the single-cycle PC register, PC-increment and halt logic with a fetch stage that drives a multi-cycle, in-order instruction memory through a request/grant/response handshake, buffers fetched words in a DEPTH-entry prefetch queue, and squashes in-flight fetches on a branch redirect. It sits between instruction memory and decode and owns the architectural fetch PC and the `hlt` output.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/fetch_queue.sv | 58 +++++
 rtl/fetch_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Definitions shared across the core front end: fetch FSM encoding,
// the default HLT opcode and the instruction byte-width helper.
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HALTING = 2'd1,
        HALTED  = 2'd2
    } fetch_state_t;

    localparam logic [3:0] HLT_OPCODE_DEFAULT = 4'hF;

    function automatic int unsigned inst_bytes(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Show-ahead synchronous FIFO: the head entry is readable combinationally,
// and a push into an empty queue becomes visible on the following cycle.
module fetch_queue #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 4,
    parameter bit FLUSH_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    logic do_push;
    logic do_pop;
    logic do_flush;

    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign head_data = mem_reg[rd_ptr_reg];

    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign do_flush = FLUSH_EN & flush;

    always_ff @(posedge clk) begin
        if (rst || do_flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only observed once counted valid.
    always_ff @(posedge clk) begin
        if (do_push && !do_flush) mem_reg[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited request issue to an in-order
// memory, prefetch queue toward decode, redirect squash and HLT handling.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                DATA_W     = 16,
    parameter int                DEPTH      = 4,
    parameter logic [DATA_W-1:0] RESET_PC   = '0,
    parameter logic [3:0]        HLT_OPCODE = HLT_OPCODE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [DATA_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [DATA_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic              hlt
);

    localparam int                CW      = $clog2(DEPTH) + 1;
    localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(inst_bytes(DATA_W));

    fetch_state_t      state_reg, state_next;
    logic [DATA_W-1:0] pc_reg, pc_next;
    logic [CW-1:0]     drop_reg, drop_next;

    logic              iq_full, iq_empty;
    logic [CW-1:0]     iq_count;
    logic [2*DATA_W-1:0] iq_head;
    logic              af_full, af_empty;
    logic [CW-1:0]     af_count;
    logic [DATA_W-1:0] af_head;

    logic              grant, resp, redir, drop_resp, enq, enq_hlt, consume, head_hlt;
    logic [CW:0]       credit_sum;

    // The address FIFO holds one entry per granted-but-unanswered request,
    // so its occupancy is the outstanding count.
    assign credit_sum = {1'b0, iq_count} + {1'b0, af_count};
    assign imem_req   = (state_reg == RUN) && !rst && (credit_sum < (CW+1)'(DEPTH))
                        && !iq_full && !af_full;
    assign imem_addr  = pc_reg;

    assign grant     = imem_req & imem_gnt;
    assign resp      = imem_rvalid & ~af_empty;
    assign redir     = redirect && (state_reg != HALTED);
    assign drop_resp = resp && ((drop_reg != '0) || redir || (state_reg != RUN));
    assign enq       = resp & ~drop_resp;
    assign enq_hlt   = enq && (imem_rdata[DATA_W-1 -: 4] == HLT_OPCODE);
    assign consume   = ~iq_empty & inst_ready;
    assign head_hlt  = (iq_head[2*DATA_W-1 -: 4] == HLT_OPCODE);

    assign inst_valid = ~iq_empty;
    assign inst       = iq_empty ? '0 : iq_head[2*DATA_W-1:DATA_W];
    assign inst_pc    = iq_empty ? '0 : iq_head[DATA_W-1:0];
    assign hlt        = (state_reg == HALTED);

    fetch_queue #(.WIDTH(2*DATA_W), .DEPTH(DEPTH), .FLUSH_EN(1'b1)) u_inst_q (
        .clk       (clk),
        .rst       (rst),
        .push      (enq),
        .push_data ({imem_rdata, af_head}),
        .pop       (consume),
        .flush     (redir),
        .full      (iq_full),
        .empty     (iq_empty),
        .count     (iq_count),
        .head_data (iq_head)
    );

    fetch_queue #(.WIDTH(DATA_W), .DEPTH(DEPTH), .FLUSH_EN(1'b0)) u_addr_q (
        .clk       (clk),
        .rst       (rst),
        .push      (grant),
        .push_data (pc_reg),
        .pop       (resp),
        .flush     (1'b0),
        .full      (af_full),
        .empty     (af_empty),
        .count     (af_count),
        .head_data (af_head)
    );

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        drop_next  = drop_reg;

        if (grant) pc_next = pc_reg + PC_STEP;

        if (redir) begin
            state_next = RUN;
            pc_next    = redirect_pc;
            // Everything still in flight after this cycle belongs to the old path.
            drop_next  = af_count + CW'(grant) - CW'(resp);
        end else begin
            if (resp && (drop_reg != '0)) drop_next = drop_reg - CW'(1);
            case (state_reg)
                RUN:     if (enq_hlt) state_next = HALTING;
                HALTING: if (consume && head_hlt) state_next = HALTED;
                default: state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
            pc_reg    <= RESET_PC;
            drop_reg  <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            drop_reg  <= drop_next;
        end
    end

endmodule
